// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the RISC-V datapath.
// Handshake: mem_read/mem_write are requests held high until the cycle in which
// mem_ready is high; that cycle completes the transfer and nothing is retained after it.
interface multicycle_controller_if #(
  parameter int RETIRE_W = 32
);
  logic [31:0]         instruction;
  logic                zero;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_src;
  logic                ir_write;
  logic                mem_read;
  logic                mem_write;
  logic                i_or_d;
  logic [1:0]          imm_sel;
  logic                alu_src;
  logic [1:0]          alu_op;
  logic                reg_write;
  logic                mem_to_reg;
  logic                illegal;
  logic [2:0]          state;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  instruction, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, imm_sel,
           alu_src, alu_op, reg_write, mem_to_reg, illegal, state, retired
  );

  modport slave (
    output instruction, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, imm_sel,
           alu_src, alu_op, reg_write, mem_to_reg, illegal, state, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a RISC-V datapath with a
// single shared memory; strobes are decoded from state plus the latched opcode/funct3.
module multicycle_controller #(
  parameter int RETIRE_W = 32
) (
  input logic                    clock,
  input logic                    reset,
  multicycle_controller_if.master bus
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;

  logic [2:0]          state_q, state_d;
  logic [6:0]          opcode_q;
  logic [2:0]          funct3_q;
  logic                illegal_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                retire;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       is_load, is_store, is_branch, is_rtype, is_ialu, is_legal;
  logic [1:0] imm_dec;

  logic       pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d;
  logic [1:0] imm_sel, alu_op;
  logic       alu_src, reg_write, mem_to_reg;

  // In DECODE the fields come straight from the IR so imm_sel is already valid there.
  assign cur_op = (state_q == S_DECODE) ? bus.instruction[6:0]   : opcode_q;
  assign cur_f3 = (state_q == S_DECODE) ? bus.instruction[14:12] : funct3_q;

  assign is_load   = (cur_op == OP_LOAD);
  assign is_store  = (cur_op == OP_STORE);
  assign is_branch = (cur_op == OP_BRANCH) && (cur_f3 == 3'b000 || cur_f3 == 3'b001);
  assign is_rtype  = (cur_op == OP_RTYPE);
  assign is_ialu   = (cur_op == OP_IALU);
  assign is_legal  = is_load | is_store | is_branch | is_rtype | is_ialu;

  always_comb begin
    imm_dec = 2'b11;
    if (is_load || is_ialu) imm_dec = 2'b00;
    else if (is_store)      imm_dec = 2'b01;
    else if (is_branch)     imm_dec = 2'b10;
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    imm_sel    = imm_dec;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      S_FETCH: begin
        imm_sel  = 2'b11;
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = is_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_branch) begin
          alu_op   = 2'b01;
          pc_src   = 1'b1;
          pc_write = (cur_f3 == 3'b000) ? bus.zero : ~bus.zero;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_rtype || is_ialu) begin
          alu_src = is_ialu;
          alu_op  = 2'b10;
          state_d = S_WB;
        end else begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = is_load;
        mem_write = is_store;
        if (bus.mem_ready) begin
          reg_write  = is_load;
          mem_to_reg = is_load;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: imm_sel = 2'b00;
      default: begin
        imm_sel = 2'b00;
        state_d = S_FETCH;
      end
    endcase
    // Reset low kills every strobe immediately, independent of the registered state.
    if (!reset) begin
      retire     = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      imm_sel    = 2'b00;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      opcode_q  <= 7'd0;
      funct3_q  <= 3'd0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        opcode_q <= bus.instruction[6:0];
        funct3_q <= bus.instruction[14:12];
        if (!is_legal) illegal_q <= 1'b1;
      end
      if (retire) retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.ir_write   = ir_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.i_or_d     = i_or_d;
  assign bus.imm_sel    = imm_sel;
  assign bus.alu_src    = alu_src;
  assign bus.alu_op     = alu_op;
  assign bus.reg_write  = reg_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.illegal    = illegal_q;
  assign bus.state      = state_q;
  assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected strobe vectors queued as
// each cycle's stimulus is driven, plus retired-count checks and reset corner cases.
module tb_multicycle_controller;
  localparam int RW = 4;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_ILL = 4;

  logic clock;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [RW-1:0] exp_retired;
  logic [16:0]   exp_q[$];

  multicycle_controller_if #(.RETIRE_W(RW)) bus ();
  multicycle_controller #(.RETIRE_W(RW)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] ins;
    int          kind;
    logic        zero;
    int          fwait;
    int          mwait;
    logic [1:0]  imm;
    logic        asrc;
    logic [1:0]  aop;
    logic        pcw;
  } vec_t;

  vec_t vecs[12];

  // {state, illegal, pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
  //  imm_sel, alu_src, alu_op, reg_write, mem_to_reg}
  function automatic logic [16:0] pk(logic [2:0] st, logic ill, logic pcw, logic src,
                                     logic irw, logic mr, logic mw, logic iod,
                                     logic [1:0] imm, logic asrc, logic [1:0] aop,
                                     logic rw, logic m2r);
    return {st, ill, pcw, src, irw, mr, mw, iod, imm, asrc, aop, rw, m2r};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.state, bus.illegal, bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read,
            bus.mem_write, bus.i_or_d, bus.imm_sel, bus.alu_src, bus.alu_op,
            bus.reg_write, bus.mem_to_reg};
  endfunction

  task automatic compare_out(input string tag);
    logic [16:0] got, exp;
    got = observed();
    exp = exp_q.pop_front();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  task automatic check_retired(input string tag);
    tests++;
    if (bus.retired !== exp_retired) begin
      fails++;
      $display("FAIL %s retired: got %0d expected %0d", tag, bus.retired, exp_retired);
    end
  endtask

  task automatic cycle(input logic [31:0] ins, input logic z, input logic rdy,
                       input logic [16:0] e, input string tag);
    @(negedge clock);
    bus.instruction = ins;
    bus.zero        = z;
    bus.mem_ready   = rdy;
    exp_q.push_back(e);
    #1;
    compare_out(tag);
  endtask

  // One FETCH cycle with memory stalled, then the retired count.
  task automatic idle_check(input string tag);
    cycle($urandom, 1'($urandom), 1'b0,
          pk(3'd0, 0, 0, 0, 0, 1, 0, 0, 2'b11, 0, 2'b00, 0, 0), {tag, " idle"});
    check_retired(tag);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    exp_q.push_back(pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    #1;
    compare_out("reset");
    exp_retired = '0;
    check_retired("reset");
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic exec_instr(input vec_t v, input string tag);
    logic ld, st, br;
    ld = (v.kind == K_LD);
    st = (v.kind == K_ST);
    br = (v.kind == K_BR);
    for (int i = 0; i < v.fwait; i++)
      cycle($urandom, 1'($urandom), 1'b0,
            pk(3'd0, 0, 0, 0, 0, 1, 0, 0, 2'b11, 0, 2'b00, 0, 0), {tag, " fetch-wait"});
    cycle($urandom, 1'($urandom), 1'b1,
          pk(3'd0, 0, 1, 0, 1, 1, 0, 0, 2'b11, 0, 2'b00, 0, 0), {tag, " fetch"});
    cycle(v.ins, 1'($urandom), 1'($urandom),
          pk(3'd1, 0, 0, 0, 0, 0, 0, 0, v.imm, 0, 2'b00, 0, 0), {tag, " decode"});
    if (v.kind == K_ILL) begin
      for (int i = 0; i < 3; i++)
        cycle($urandom, 1'($urandom), 1'($urandom),
              pk(3'd5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0), {tag, " trap"});
      check_retired({tag, " trap"});
      return;
    end
    cycle($urandom, v.zero, 1'($urandom),
          pk(3'd2, 0, br ? v.pcw : 1'b0, br, 0, 0, 0, 0, v.imm, v.asrc, v.aop, 0, 0),
          {tag, " exec"});
    if (ld || st) begin
      for (int i = 0; i < v.mwait; i++)
        cycle($urandom, 1'($urandom), 1'b0,
              pk(3'd3, 0, 0, 0, 0, ld, st, 1, v.imm, 0, 2'b00, 0, 0), {tag, " mem-wait"});
      cycle($urandom, 1'($urandom), 1'b1,
            pk(3'd3, 0, 0, 0, 0, ld, st, 1, v.imm, 0, 2'b00, ld, ld), {tag, " mem"});
    end else if (!br) begin
      cycle($urandom, 1'($urandom), 1'($urandom),
            pk(3'd4, 0, 0, 0, 0, 0, 0, 0, v.imm, 0, 2'b00, 1, 0), {tag, " wb"});
    end
    exp_retired = exp_retired + 1'b1;
    idle_check(tag);
  endtask

  initial begin
    vec_t v;
    reset           = 1'b0;
    bus.instruction = 32'd0;
    bus.zero        = 1'b0;
    bus.mem_ready   = 1'b0;
    exp_retired     = '0;

    //          ins           kind   zero fw mw imm    asrc aop    pcw
    vecs[0]  = '{32'h002081B3, K_ALU, 0, 0, 0, 2'b11, 0, 2'b10, 0}; // add
    vecs[1]  = '{32'h00500093, K_ALU, 0, 0, 0, 2'b00, 1, 2'b10, 0}; // addi
    vecs[2]  = '{32'h00412083, K_LD,  0, 0, 3, 2'b00, 1, 2'b00, 0}; // lw, stalled
    vecs[3]  = '{32'h00208463, K_BR,  1, 0, 0, 2'b10, 0, 2'b01, 1}; // beq taken
    vecs[4]  = '{32'h00208463, K_BR,  0, 0, 0, 2'b10, 0, 2'b01, 0}; // beq not taken
    vecs[5]  = '{32'h00209463, K_BR,  0, 0, 0, 2'b10, 0, 2'b01, 1}; // bne taken
    vecs[6]  = '{32'h00209463, K_BR,  1, 0, 0, 2'b10, 0, 2'b01, 0}; // bne not taken
    vecs[7]  = '{32'h0020A223, K_ST,  0, 0, 0, 2'b01, 1, 2'b00, 0}; // sw
    vecs[8]  = '{32'h00412083, K_LD,  0, 2, 0, 2'b00, 1, 2'b00, 0}; // lw, fetch stalled
    vecs[9]  = '{32'h402081B3, K_ALU, 0, 0, 0, 2'b11, 0, 2'b10, 0}; // sub
    vecs[10] = '{32'h0000007F, K_ILL, 0, 0, 0, 2'b11, 0, 2'b00, 0}; // bad opcode
    vecs[11] = '{32'h0020A463, K_ILL, 0, 0, 0, 2'b11, 0, 2'b00, 0}; // branch funct3=010

    #1;
    exp_q.push_back(pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    compare_out("initial reset");
    check_retired("initial reset");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      exec_instr(vecs[i], $sformatf("vec%0d", i));
      if (vecs[i].kind == K_ILL) apply_reset();
    end

    // Reset pulsed low while a load is stalled in MEM.
    v = vecs[2];
    cycle($urandom, 0, 1'b1, pk(3'd0, 0, 1, 0, 1, 1, 0, 0, 2'b11, 0, 2'b00, 0, 0), "mr fetch");
    cycle(v.ins, 0, 1'b0, pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0), "mr decode");
    cycle($urandom, 0, 1'b0, pk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0), "mr exec");
    cycle($urandom, 0, 1'b0, pk(3'd3, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0, 2'b00, 0, 0), "mr mem");
    #1;
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    exp_q.push_back(pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    #1;
    compare_out("mr async drop");
    exp_retired = '0;
    check_retired("mr async drop");
    @(negedge clock);
    exp_q.push_back(pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    compare_out("mr held");
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    exec_instr(vecs[0], "mr restart");

    // Retired counter wraps modulo 2^RW.
    apply_reset();
    for (int i = 0; i < 17; i++) exec_instr(vecs[$urandom_range(0, 9)], $sformatf("wrap%0d", i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the RISC-V datapath.
- Latches the instruction class at decode and steps FETCH→DECODE→EXEC→MEM→WB.
- Drives every datapath strobe, including the immediate-format select that feeds the immediate generator, the ALU source/op and the register-file write.
- Handshakes with a single shared instruction/data memory through mem_ready and counts retired instructions.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- instruction  input  32  current IR contents; sampled only in DECODE.
- zero  input  1  ALU zero flag; valid in EXEC.
- mem_ready  input  1  memory completes the pending read/write this cycle.
- pc_write  output  1  load PC (PC+4 in FETCH, branch target in EXEC).
- pc_src  output  1  0 = PC+4, 1 = branch target.
- ir_write  output  1  load IR from memory read data.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- i_or_d  output  1  0 = instruction address (PC), 1 = data address (ALU result).
- imm_sel  output  2  00 I-type, 01 S-type, 10 B-type, 11 none.
- alu_src  output  1  0 = rs2, 1 = immediate.
- alu_op  output  2  00 add, 01 sub, 10 decode funct3/funct7.
- reg_write  output  1  register-file write enable.
- mem_to_reg  output  1  write-back source: 1 = memory data, 0 = ALU.
- illegal  output  1  sticky illegal-instruction flag.
- state  output  3  current state, for debug.
- retired  output  RETIRE_W  retired-instruction count.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset low, asynchronous:
  - state=FETCH, latched opcode/funct3 = 0, illegal=0, retired=0.
  - All strobes forced 0 while reset is low, regardless of state.
- Output timing:
  - Strobes are decoded combinationally from state plus the latched fields.
  - pc_write/ir_write in FETCH and reg_write in MEM are additionally qualified by mem_ready.
- FETCH:
  - mem_read=1, i_or_d=0.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
  - Else hold FETCH indefinitely; no PC/IR change.
- DECODE:
  - Latch opcode = instruction[6:0] and funct3 = instruction[14:12].
  - Classes: load 0000011, store 0100011, branch 1100011 with funct3 000 (beq) or 001 (bne), R-type 0110011, I-ALU 0010011.
  - Any other opcode, or a branch with any other funct3, goes to TRAP. Legal classes go to EXEC.
  - imm_sel is valid from DECODE onward: I for load/I-ALU, S for store, B for branch, 11 for R-type.
- EXEC:
  - Load/store: alu_src=1, alu_op=00, go to MEM.
  - R-type: alu_src=0, alu_op=10, go to WB.
  - I-ALU: alu_src=1, alu_op=10, go to WB.
  - Branch: alu_src=0, alu_op=01, pc_src=1. pc_write = zero for beq, ~zero for bne. Retire, then go to FETCH.
- MEM:
  - i_or_d=1.
  - Load: mem_read=1. On mem_ready, reg_write=1, mem_to_reg=1, retire, go to FETCH (write-back merged into this cycle).
  - Store: mem_write=1. On mem_ready, retire, go to FETCH.
  - No mem_ready: hold MEM with the request asserted.
- WB (R-type/I-ALU only): reg_write=1, mem_to_reg=0, retire, go to FETCH.
- TRAP:
  - illegal=1, all strobes 0, state held until reset.
  - retired does not increment for the offending instruction.
- retired:
  - Increments by 1 on the clock edge ending the retiring cycle.
  - Wraps modulo 2^RETIRE_W.
- Latency with mem_ready always 1: branch 3 cycles; R-type, I-ALU, store 4 cycles; load 4 cycles.
- Reset asserted mid-instruction: strobes drop immediately; the next instruction restarts in FETCH after release; the partial instruction is not counted.
- The instruction input may change outside DECODE without effect; the latched fields govern EXEC/MEM/WB.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3) with mem_ready=1 → states 0,1,2,4,0; reg_write=1 only in WB, alu_op=10, imm_sel=11; retired=1.
- Load 0x00412083 with mem_ready low for 3 cycles in MEM → MEM held 4 cycles, mem_read=1, i_or_d=1 throughout; reg_write and mem_to_reg pulse once with mem_ready; imm_sel=00; retired=1.
- beq 0x00208463: zero=1 → pc_write=1, pc_src=1 in EXEC, imm_sel=10. Repeat with zero=0 → pc_write=0. Both take 3 cycles.
- Store 0x0020A223 → imm_sel=01, mem_write=1 in MEM for exactly one cycle with mem_ready=1, reg_write never asserts.
- Opcode 0x0000007F, or branch funct3=010 → TRAP after DECODE, illegal=1 sticky, no strobes, retired unchanged; reset low clears illegal and returns to FETCH.
- Reset pulsed low during MEM of a load → mem_read drops asynchronously, reg_write never fires, retired unchanged, FETCH restarts after release.
